// File: rtl/core_pkg.sv
// Shared types and widths for the single-cycle core front end.
package core_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;

  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous DEPTH-entry FIFO of {pc, instruction} pairs; flush beats push/pop.
module fetch_fifo
  import core_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  fetch_entry_t                 din,
  output fetch_entry_t                 dout,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;

  assign do_pop  = pop & ~empty;
  // A full FIFO can still accept a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!flush && do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch initiator: pc register, fire/fault decision, redirect flush,
// and a registered {pc, instruction} FIFO toward decode.
module ifetch_unit
  import core_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned       MEM_BYTES = 65536,
  parameter int unsigned       DEPTH     = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_en,
  output logic [ADDR_W-1:0]  iaddr,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic               fault,
  output logic [ADDR_W-1:0]  fault_pc
);

  localparam int unsigned CNT_W     = $clog2(DEPTH + 1);
  localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              fault_q, fault_d;
  logic [ADDR_W-1:0] fault_pc_q, fault_pc_d;

  logic              in_range, fetch_ok, pop, fire, fault_set;
  fetch_entry_t      fifo_din, fifo_dout;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full, fifo_empty;
  logic              unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // 33-bit sum so a pc near the top of the address space cannot wrap into range.
  assign in_range  = ({1'b0, pc_q} + 33'd3) < MEM_LIMIT;
  assign fetch_ok  = fetch_en & ~fault_q & ~redirect_valid;
  assign pop       = if_valid & if_ready;
  assign fire      = fetch_ok & in_range & (~fifo_full | pop);
  assign fault_set = fetch_ok & ~in_range;

  always_comb begin
    pc_d       = pc_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    if (redirect_valid) begin
      pc_d    = {redirect_pc[ADDR_W-1:2], 2'b00};
      fault_d = 1'b0;
    end else if (fire) begin
      pc_d = pc_q + ADDR_W'(4);
    end else if (fault_set) begin
      fault_d    = 1'b1;
      fault_pc_d = pc_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
    end else begin
      pc_q       <= pc_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  assign fifo_din.pc    = pc_q;
  assign fifo_din.instr = instruction;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fire),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  a_count_bound: assert property (@(posedge clk) disable iff (reset)
    fifo_count <= CNT_W'(DEPTH));

  assign iaddr    = pc_q;
  assign if_valid = ~fifo_empty;
  assign if_instr = fifo_dout.instr;
  assign if_pc    = fifo_dout.pc;
  assign fault    = fault_q;
  assign fault_pc = fault_pc_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit with a combinational instruction memory model.
module tb_ifetch_unit;
  import core_pkg::*;

  logic        clk, reset, fetch_en, redirect_valid, if_ready;
  logic [31:0] iaddr, instruction, redirect_pc, if_instr, if_pc, fault_pc;
  logic        if_valid, fault;

  int n_vec = 0;
  int n_bad = 0;

  // Reference state: expected pc, expected FIFO contents, expected fault.
  logic [31:0]  mdl_pc;
  logic         mdl_fault;
  logic [31:0]  mdl_fault_pc;
  fetch_entry_t exp_q [$];

  ifetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .MEM_BYTES (65536),
    .DEPTH     (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_en       (fetch_en),
    .iaddr          (iaddr),
    .instruction    (instruction),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .fault          (fault),
    .fault_pc       (fault_pc)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
  endfunction

  assign instruction = mem_word(iaddr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic fetch_entry_t head();
    fetch_entry_t e;
    e = '0;
    if (exp_q.size() != 0) e = exp_q[0];
    return e;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    mdl_pc       = 32'h0;
    mdl_fault    = 1'b0;
    mdl_fault_pc = 32'h0;
  endtask

  // Advance the reference model across one rising edge, then settle at the falling edge.
  task automatic tick();
    fetch_entry_t e;
    int           sz;
    bit           pop, inr, fire;
    sz  = exp_q.size();
    pop = (sz != 0) && if_ready;
    inr = ({32'd0, mdl_pc} + 64'd3) < 64'd65536;
    @(posedge clk);
    if (redirect_valid) begin
      exp_q.delete();
      mdl_pc    = {redirect_pc[31:2], 2'b00};
      mdl_fault = 1'b0;
    end else begin
      fire = fetch_en && !mdl_fault && inr && (sz < 2 || pop);
      if (pop) void'(exp_q.pop_front());
      if (fire) begin
        e.pc    = mdl_pc;
        e.instr = mem_word(mdl_pc);
        exp_q.push_back(e);
        mdl_pc = mdl_pc + 32'd4;
      end else if (fetch_en && !mdl_fault && !inr) begin
        mdl_fault    = 1'b1;
        mdl_fault_pc = mdl_pc;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; fetch_en = 1'b0; if_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    model_reset();
    @(negedge clk);
    n_vec++;
    if (iaddr !== 32'h0 || if_valid !== 1'b0 || if_instr !== 32'h0 || if_pc !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got iaddr=%h v=%b ins=%h pc=%h, want 0 0 0 0",
               iaddr, if_valid, if_instr, if_pc);
    end
    n_vec++;
    if (fault !== 1'b0 || fault_pc !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_fault: got fault=%b fault_pc=%h, want 0 0", fault, fault_pc);
    end
    reset = 1'b0;
  endtask

  task automatic test_stream();
    fetch_entry_t h;
    fetch_en = 1'b1; if_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      h = head();
      n_vec++;
      if (iaddr !== 32'(4 * i)) begin
        n_bad++;
        $display("FAIL stream_iaddr %0d: got %h, want %h", i, iaddr, 32'(4 * i));
      end
      n_vec++;
      if (if_valid !== (i > 0) || (i > 0 && (if_pc !== 32'(4 * (i - 1)) ||
          if_instr !== mem_word(32'(4 * (i - 1)))))) begin
        n_bad++;
        $display("FAIL stream_head %0d: got v=%b pc=%h ins=%h, want v=%b pc=%h ins=%h", i,
                 if_valid, if_pc, if_instr, i > 0, h.pc, h.instr);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    redirect_valid = 1'b1; redirect_pc = 32'h0; if_ready = 1'b0;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    n_vec++;
    if (iaddr !== 32'h8 || if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== mem_word(0)) begin
      n_bad++;
      $display("FAIL bp_full: got iaddr=%h v=%b pc=%h ins=%h, want 8 1 0 %h",
               iaddr, if_valid, if_pc, if_instr, mem_word(0));
    end
    if_ready = 1'b1;
    tick();
    n_vec++;
    if (iaddr !== 32'hC || if_pc !== 32'h4) begin
      n_bad++;
      $display("FAIL bp_full_pop: got iaddr=%h pc=%h, want 0000000c 00000004", iaddr, if_pc);
    end
    tick();
    n_vec++;
    if (if_pc !== 32'h8 || if_instr !== mem_word(32'h8) || iaddr !== 32'h10) begin
      n_bad++;
      $display("FAIL bp_drain: got pc=%h ins=%h iaddr=%h, want 8 %h 10",
               if_pc, if_instr, iaddr, mem_word(32'h8));
    end
  endtask

  task automatic test_redirect();
    if_ready = 1'b0;
    tick(); tick();
    n_vec++;
    if (exp_q.size() != 2 || if_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL redir_setup: got v=%b, want 1 with %0d queued", if_valid, exp_q.size());
    end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0023; if_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    n_vec++;
    if (if_valid !== 1'b0 || iaddr !== 32'h20) begin
      n_bad++;
      $display("FAIL redir_flush: got v=%b iaddr=%h, want 0 00000020", if_valid, iaddr);
    end
    tick();
    n_vec++;
    if (if_valid !== 1'b1 || if_pc !== 32'h20 || if_instr !== mem_word(32'h20)) begin
      n_bad++;
      $display("FAIL redir_target: got v=%b pc=%h ins=%h, want 1 00000020 %h",
               if_valid, if_pc, if_instr, mem_word(32'h20));
    end
  endtask

  task automatic test_fault();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_FFFC;
    tick();
    redirect_pc = 32'h0000_FFFE;
    tick();
    n_vec++;
    if (iaddr !== 32'hFFFC || if_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL fault_align: got iaddr=%h v=%b, want 0000fffc 0", iaddr, if_valid);
    end
    redirect_valid = 1'b0;
    tick();
    n_vec++;
    if (iaddr !== 32'h1_0000 || fault !== 1'b0 || if_pc !== 32'hFFFC) begin
      n_bad++;
      $display("FAIL fault_last_legal: got iaddr=%h fault=%b pc=%h, want 00010000 0 0000fffc",
               iaddr, fault, if_pc);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_vec++;
      if (fault !== 1'b1 || fault_pc !== 32'h1_0000 || iaddr !== 32'h1_0000 ||
          if_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL fault_set %0d: got fault=%b fpc=%h iaddr=%h v=%b, want 1 10000 10000 0",
                 i, fault, fault_pc, iaddr, if_valid);
      end
    end
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    tick();
    redirect_valid = 1'b0;
    n_vec++;
    if (fault !== 1'b0 || fault_pc !== 32'h1_0000 || iaddr !== 32'h0) begin
      n_bad++;
      $display("FAIL fault_clear: got fault=%b fpc=%h iaddr=%h, want 0 00010000 0",
               fault, fault_pc, iaddr);
    end
    tick();
    n_vec++;
    if (iaddr !== 32'h4 || if_pc !== 32'h0 || if_instr !== mem_word(0)) begin
      n_bad++;
      $display("FAIL fault_resume: got iaddr=%h pc=%h ins=%h, want 4 0 %h",
               iaddr, if_pc, if_instr, mem_word(0));
    end
  endtask

  task automatic test_midreset();
    if_ready = 1'b0;
    tick(); tick(); tick();
    #2 reset = 1'b1;
    #1;
    n_vec++;
    if (iaddr !== 32'h0 || if_valid !== 1'b0 || fault !== 1'b0 || if_pc !== 32'h0) begin
      n_bad++;
      $display("FAIL midreset: got iaddr=%h v=%b fault=%b pc=%h, want 0 0 0 0",
               iaddr, if_valid, fault, if_pc);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_fetch_en();
    logic [31:0] hold_pc;
    fetch_en = 1'b1; if_ready = 1'b1;
    tick(); tick(); tick();
    fetch_en = 1'b0;
    hold_pc = mdl_pc;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (iaddr !== hold_pc) begin
        n_bad++;
        $display("FAIL fen_hold %0d: got iaddr=%h, want %h", i, iaddr, hold_pc);
      end
    end
    n_vec++;
    if (if_valid !== 1'b0 || hold_pc !== 32'hC) begin
      n_bad++;
      $display("FAIL fen_drain: got v=%b held=%h, want 0 0000000c", if_valid, hold_pc);
    end
    fetch_en = 1'b1;
    tick();
    n_vec++;
    if (iaddr !== hold_pc + 32'd4 || if_pc !== hold_pc || if_instr !== mem_word(hold_pc)) begin
      n_bad++;
      $display("FAIL fen_resume: got iaddr=%h pc=%h ins=%h, want %h %h %h",
               iaddr, if_pc, if_instr, hold_pc + 32'd4, hold_pc, mem_word(hold_pc));
    end
  endtask

  task automatic test_back_to_back();
    fetch_entry_t h;
    for (int i = 0; i < 80; i++) begin
      if_ready       = ($urandom_range(0, 3) != 0);
      fetch_en       = ($urandom_range(0, 7) != 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 1) == 0) redirect_pc = 32'h0000_FFE0 + 32'($urandom_range(0, 31));
      else                           redirect_pc = 32'($urandom_range(0, 32'hFFFF));
      h = head();
      n_vec++;
      if (iaddr !== mdl_pc || if_valid !== (exp_q.size() != 0) || if_pc !== h.pc ||
          if_instr !== h.instr || fault !== mdl_fault || fault_pc !== mdl_fault_pc) begin
        n_bad++;
        $display("FAIL b2b %0d: got ia=%h v=%b pc=%h ins=%h f=%b fpc=%h, want %h %b %h %h %b %h",
                 i, iaddr, if_valid, if_pc, if_instr, fault, fault_pc, mdl_pc,
                 exp_q.size() != 0, h.pc, h.instr, mdl_fault, mdl_fault_pc);
      end
      tick();
    end
    redirect_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_fault();
    test_midreset();
    test_fetch_en();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
